// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
`default_nettype none

package mem_access_stage_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [2:0] WB_ALU  = 3'd0;
  localparam logic [2:0] WB_MEM  = 3'd1;
  localparam logic [2:0] WB_SET  = 3'd2;
  localparam logic [2:0] WB_PC   = 3'd3;
  localparam logic [2:0] WB_REG2 = 3'd4;

  localparam int TIMEOUT_CYCLES_DEF = 15;

endpackage

`default_nettype wire

// File: rtl/mem_access_stage_mem_wb_reg.sv
// MEM/WB pipeline register: async active-low reset, loads a bubble when bubble_i is set.
`default_nettype none

module mem_wb_reg (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        bubble_i,
  input  logic [15:0] data_i,
  input  logic        regwrt_i,
  input  logic [2:0]  wreg_i,
  input  logic        halt_i,
  input  logic        err_i,
  output logic [15:0] data_o,
  output logic        regwrt_o,
  output logic [2:0]  wreg_o,
  output logic        halt_o,
  output logic        err_o
);

  logic [15:0] data_q;
  logic        regwrt_q;
  logic [2:0]  wreg_q;
  logic        halt_q;
  logic        err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni || bubble_i) begin
      data_q   <= '0;
      regwrt_q <= 1'b0;
      wreg_q   <= '0;
      halt_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      data_q   <= data_i;
      regwrt_q <= regwrt_i;
      wreg_q   <= wreg_i;
      halt_q   <= halt_i;
      err_q    <= err_i;
    end
  end

  assign data_o   = data_q;
  assign regwrt_o = regwrt_q;
  assign wreg_o   = wreg_q;
  assign halt_o   = halt_q;
  assign err_o    = err_q;

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// Memory-access stage: variable-latency load/store handshake with timeout, write-back select.
// Optional macro MEM_ALIGN_CHECK_EN rejects odd addresses with err instead of issuing them.
`default_nettype none

module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] aluOut,
  input  logic [15:0] reg2Data,
  input  logic [15:0] setVal,
  input  logic [15:0] nextPc,
  input  logic        memEn,
  input  logic        memWrt,
  input  logic        regWrt,
  input  logic [2:0]  regWrtSrc,
  input  logic [2:0]  writeReg,
  input  logic        halt,
  input  logic        errIn,
  output logic        memReq,
  output logic        memWr,
  output logic [15:0] memAddr,
  output logic [15:0] memWData,
  input  logic [15:0] memRData,
  input  logic        memDone,
  output logic        stallOut,
  output logic [15:0] wbData,
  output logic        wbRegWrt,
  output logic [2:0]  wbWriteReg,
  output logic        wbHalt,
  output logic        err
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        misaligned;
  logic [15:0] load_data;
  logic [15:0] sel_data;
  logic        sel_err;
  logic        req;
  logic        stall;
  logic        bubble;
  logic [15:0] wb_data_d;
  logic        wb_regwrt_d;
  logic        wb_err_d;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = aluOut[0];
`else
  assign misaligned = 1'b0;
`endif

  // Stores never contribute load data, so a store with the load source yields 0.
  assign load_data = (memEn && !memWrt) ? memRData : 16'h0000;

  always_comb begin
    sel_data = 16'h0000;
    sel_err  = 1'b0;
    case (regWrtSrc)
      WB_ALU:  sel_data = aluOut;
      WB_MEM:  sel_data = load_data;
      WB_SET:  sel_data = setVal;
      WB_PC:   sel_data = nextPc;
      WB_REG2: sel_data = reg2Data;
      default: sel_err  = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req         = 1'b0;
    stall       = 1'b0;
    bubble      = 1'b0;
    wb_data_d   = sel_data;
    wb_regwrt_d = regWrt;
    wb_err_d    = errIn | sel_err;
    case (state_q)
      IDLE: begin
        if (memEn && !misaligned) begin
          req     = 1'b1;
          stall   = 1'b1;
          bubble  = 1'b1;
          state_d = WAIT;
          cnt_d   = '0;
        end else if (memEn) begin
          wb_data_d   = 16'h0000;
          wb_regwrt_d = 1'b0;
          wb_err_d    = 1'b1;
        end
      end
      WAIT: begin
        req = 1'b1;
        if (memDone) begin
          state_d = IDLE;
        end else if (cnt_q == TMO_LAST) begin
          state_d     = IDLE;
          wb_data_d   = 16'h0000;
          wb_regwrt_d = 1'b0;
          wb_err_d    = 1'b1;
        end else begin
          stall  = 1'b1;
          bubble = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gated by reset so the request drops immediately, even while memEn is held.
  assign memReq   = rst & req;
  assign stallOut = rst & stall;
  assign memWr    = memReq & memWrt;
  assign memAddr  = aluOut;
  assign memWData = reg2Data;

  mem_wb_reg u_mem_wb_reg (
    .clk_i    (clk),
    .rst_ni   (rst),
    .bubble_i (bubble),
    .data_i   (wb_data_d),
    .regwrt_i (wb_regwrt_d),
    .wreg_i   (writeReg),
    .halt_i   (halt),
    .err_i    (wb_err_d),
    .data_o   (wbData),
    .regwrt_o (wbRegWrt),
    .wreg_o   (wbWriteReg),
    .halt_o   (wbHalt),
    .err_o    (err)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: vector table plus handshake sequences.
`default_nettype none

module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] aluOut, reg2Data, setVal, nextPc, memRData;
  logic        memEn, memWrt, regWrt, halt, errIn, memDone;
  logic [2:0]  regWrtSrc, writeReg;
  logic        memReq, memWr, stallOut, wbRegWrt, wbHalt, err;
  logic [15:0] memAddr, memWData, wbData;
  logic [2:0]  wbWriteReg;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] data;
    logic        regwrt;
    logic [2:0]  wreg;
    logic        halt;
    logic        err;
  } wb_t;

  typedef struct {
    logic [2:0]  src;
    logic [15:0] alu, reg2, setv, pc;
    logic        rw;
    logic [2:0]  wreg;
    logic        h, ein;
    logic [15:0] e_data;
    logic        e_err;
  } vec_t;

  wb_t exp_q[$];

  mem_access_stage dut (
    .clk(clk), .rst(rst), .aluOut(aluOut), .reg2Data(reg2Data), .setVal(setVal),
    .nextPc(nextPc), .memEn(memEn), .memWrt(memWrt), .regWrt(regWrt),
    .regWrtSrc(regWrtSrc), .writeReg(writeReg), .halt(halt), .errIn(errIn),
    .memReq(memReq), .memWr(memWr), .memAddr(memAddr), .memWData(memWData),
    .memRData(memRData), .memDone(memDone), .stallOut(stallOut), .wbData(wbData),
    .wbRegWrt(wbRegWrt), .wbWriteReg(wbWriteReg), .wbHalt(wbHalt), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic wb_t mk(logic [15:0] d, logic rw, logic [2:0] wr, logic h, logic e);
    wb_t w;
    w.data = d; w.regwrt = rw; w.wreg = wr; w.halt = h; w.err = e;
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_wb(input string nm);
    wb_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got wb output want empty scoreboard entry", nm);
    end else begin
      e = exp_q.pop_front();
      chk(nm, {10'd0, wbData, wbRegWrt, wbWriteReg, wbHalt, err}, {10'd0, e});
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_access(input string nm, input logic wr, input logic [15:0] a,
                            input logic [15:0] d, input logic [2:0] src, input logic rw,
                            input logic [2:0] wreg, input logic h, input int lat,
                            input logic [15:0] rdata, input wb_t e);
    memEn = 1'b1; memWrt = wr; aluOut = a; reg2Data = d; regWrtSrc = src;
    regWrt = rw; writeReg = wreg; halt = h; errIn = 1'b0;
    exp_q.push_back(e);
    for (int i = 0; i < lat; i++) begin
      #1;
      chk({nm, "_req"},   {31'd0, memReq}, 32'd1);
      chk({nm, "_stall"}, {31'd0, stallOut}, 32'd1);
      chk({nm, "_wr"},    {31'd0, memWr}, {31'd0, wr});
      chk({nm, "_addr"},  {16'd0, memAddr}, {16'd0, a});
      chk({nm, "_wdata"}, {16'd0, memWData}, {16'd0, d});
      if (i > 0) chk({nm, "_bubble"}, {30'd0, wbRegWrt, err}, 32'd0);
      step;
    end
    memDone = 1'b1; memRData = rdata;
    #1;
    chk({nm, "_done_stall"}, {31'd0, stallOut}, 32'd0);
    step;
    memDone = 1'b0; memRData = 16'hDEAD;
    check_wb({nm, "_wb"});
  endtask

  vec_t vt[7];

  initial begin
    vt[0] = '{3'd0, 16'h1234, 16'hAAAA, 16'h0001, 16'h0102, 1'b1, 3'd5, 1'b0, 1'b0, 16'h1234, 1'b0};
    vt[1] = '{3'd2, 16'h2222, 16'hBBBB, 16'h0001, 16'h0204, 1'b1, 3'd2, 1'b0, 1'b0, 16'h0001, 1'b0};
    vt[2] = '{3'd3, 16'h3333, 16'hCCCC, 16'h0000, 16'h0306, 1'b1, 3'd7, 1'b0, 1'b0, 16'h0306, 1'b0};
    vt[3] = '{3'd4, 16'h4444, 16'h5A5A, 16'h0001, 16'h0408, 1'b0, 3'd1, 1'b0, 1'b0, 16'h5A5A, 1'b0};
    vt[4] = '{3'd5, 16'h5555, 16'hDDDD, 16'h0001, 16'h050A, 1'b1, 3'd4, 1'b0, 1'b0, 16'h0000, 1'b1};
    vt[5] = '{3'd7, 16'h6666, 16'hEEEE, 16'h0001, 16'h060C, 1'b1, 3'd6, 1'b0, 1'b0, 16'h0000, 1'b1};
    vt[6] = '{3'd0, 16'hFFFF, 16'h1111, 16'h0001, 16'h070E, 1'b1, 3'd3, 1'b1, 1'b1, 16'hFFFF, 1'b1};

    rst = 1'b0; memEn = 1'b1; memWrt = 1'b0; regWrt = 1'b1; regWrtSrc = 3'd0;
    writeReg = 3'd1; halt = 1'b0; errIn = 1'b0; aluOut = 16'h0010; reg2Data = 16'h0;
    setVal = 16'h0; nextPc = 16'h0; memRData = 16'h0; memDone = 1'b0;

    // Reset holds request and stall low even with memEn asserted.
    #3;
    chk("rst_req",   {31'd0, memReq}, 32'd0);
    chk("rst_stall", {31'd0, stallOut}, 32'd0);
    chk("rst_wb",    {10'd0, wbData, wbRegWrt, wbWriteReg, wbHalt, err}, 32'd0);
    memEn = 1'b0;
    step;
    step;
    rst = 1'b1;
    step;

    foreach (vt[k]) begin
      memEn = 1'b0; regWrtSrc = vt[k].src; aluOut = vt[k].alu; reg2Data = vt[k].reg2;
      setVal = vt[k].setv; nextPc = vt[k].pc; regWrt = vt[k].rw; writeReg = vt[k].wreg;
      halt = vt[k].h; errIn = vt[k].ein;
      exp_q.push_back(mk(vt[k].e_data, vt[k].rw, vt[k].wreg, vt[k].h, vt[k].e_err));
      #1;
      chk($sformatf("vec%0d_stall", k), {30'd0, stallOut, memReq}, 32'd0);
      step;
      check_wb($sformatf("vec%0d_wb", k));
    end

    // Asynchronous clear of a non-zero MEM/WB register.
    #2 rst = 1'b0;
    #1;
    chk("async_wb", {10'd0, wbData, wbRegWrt, wbWriteReg, wbHalt, err}, 32'd0);
    errIn = 1'b0; halt = 1'b0;
    #1 rst = 1'b1;
    step;

    run_access("load", 1'b0, 16'h0100, 16'h0000, 3'd1, 1'b1, 3'd3, 1'b0, 3, 16'hBEEF,
               mk(16'hBEEF, 1'b1, 3'd3, 1'b0, 1'b0));
    run_access("store", 1'b1, 16'h0040, 16'h00AA, 3'd1, 1'b0, 3'd2, 1'b0, 1, 16'h1111,
               mk(16'h0000, 1'b0, 3'd2, 1'b0, 1'b0));
    run_access("b2b_a", 1'b0, 16'h0200, 16'h0000, 3'd1, 1'b1, 3'd4, 1'b0, 1, 16'h1357,
               mk(16'h1357, 1'b1, 3'd4, 1'b0, 1'b0));
    run_access("b2b_b", 1'b0, 16'h0300, 16'h0000, 3'd0, 1'b1, 3'd6, 1'b0, 2, 16'h2468,
               mk(16'h0300, 1'b1, 3'd6, 1'b0, 1'b0));
    run_access("halt_ld", 1'b0, 16'h0400, 16'h0000, 3'd1, 1'b1, 3'd7, 1'b1, 2, 16'hCAFE,
               mk(16'hCAFE, 1'b1, 3'd7, 1'b1, 1'b0));
    memEn = 1'b0; halt = 1'b0;
    step;

    // Timeout: 15 stalled cycles, the 16th drops stall and err lands on the next edge.
    memEn = 1'b1; memWrt = 1'b0; aluOut = 16'h0500; regWrtSrc = 3'd1; regWrt = 1'b1;
    writeReg = 3'd2; halt = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("tmo_stall%0d", i), {31'd0, stallOut}, (i < 15) ? 32'd1 : 32'd0);
      if (i > 0) chk($sformatf("tmo_bubble%0d", i), {30'd0, wbRegWrt, err}, 32'd0);
      step;
    end
    chk("tmo_wb", {29'd0, wbRegWrt, wbHalt, err}, {29'd0, 1'b0, 1'b1, 1'b1});
    memEn = 1'b0; halt = 1'b0;
    #1;
    chk("tmo_after_stall", {30'd0, stallOut, memReq}, 32'd0);
    step;

    // Reset in the middle of WAIT, then a stray memDone in IDLE must be ignored.
    memEn = 1'b1; regWrtSrc = 3'd1; writeReg = 3'd2;
    step;
    step;
    chk("midwait_req", {31'd0, memReq}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midwait_rst", {29'd0, memReq, stallOut, wbRegWrt}, 32'd0);
    memEn = 1'b0;
    step;
    #2 rst = 1'b1;
    step;
    memDone = 1'b1; memRData = 16'h9999; regWrtSrc = 3'd0; aluOut = 16'h7777;
    writeReg = 3'd6; regWrt = 1'b1;
    exp_q.push_back(mk(16'h7777, 1'b1, 3'd6, 1'b0, 1'b0));
    #1;
    chk("stray_done_req", {30'd0, memReq, stallOut}, 32'd0);
    step;
    memDone = 1'b0;
    check_wb("stray_done_wb");

`ifdef MEM_ALIGN_CHECK_EN
    memEn = 1'b1; aluOut = 16'h0041; regWrtSrc = 3'd0; regWrt = 1'b1; writeReg = 3'd3;
    halt = 1'b1;
    #1;
    chk("align_req", {30'd0, memReq, stallOut}, 32'd0);
    step;
    chk("align_wb", {29'd0, wbRegWrt, wbHalt, err}, {29'd0, 1'b0, 1'b1, 1'b1});
    memEn = 1'b0; halt = 1'b0;
`else
    run_access("odd_addr", 1'b0, 16'h0041, 16'h0000, 3'd0, 1'b1, 3'd3, 1'b0, 1, 16'h0000,
               mk(16'h0041, 1'b1, 3'd3, 1'b0, 1'b0));
    memEn = 1'b0;
`endif
    step;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
